dmem_bridge64: RTL and testbench
================================

Name: dmem_bridge64

Overview:
Responder-side data-memory bridge for the 64-bit multicycle RISC-V datapath. It accepts load/store requests from the datapath (address from AluOut, store data from register B, funct3 from the instruction) and serves them on a 32-bit synchronous byte-enabled memory port. Doubleword accesses are split into two beats. Sub-word loads are lane-extracted and sign- or zero-extended, and misaligned or illegal accesses are flagged.

Parameters:
ADDR_W, 32, memory-side address width; request address bits [ADDR_W-1:0] are forwarded to memory.
ERR_RDATA, 64'h0, value driven on rsp_rdata when rsp_err=1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request strobe; accepted when req_valid && req_ready
req_write  in  1  1=store, 0=load
req_funct3  in  3  0 b, 1 h, 2 w, 3 d, 4 bu, 5 hu, 6 wu, 7 illegal
req_addr  in  64  byte address
req_wdata  in  64  store data, right-aligned
req_ready  out  1  high only in IDLE
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  64  extended load data; 0 for stores
rsp_err  out  1  valid with rsp_valid
mem_addr  out  ADDR_W  word-aligned address
mem_wdata  out  32  lane-shifted store data
mem_be  out  4  byte enables for writes
mem_wr  out  1  write strobe
mem_rd  out  1  read strobe; mem_rdata is valid the next cycle
mem_rdata  in  32  read data

Behaviour:
- Reset: rst low forces state to IDLE immediately. req_ready=1; every other output is 0, including rsp_rdata and the internal data and request registers.
- Acceptance: on req_valid && req_ready, latch addr, funct3, write and wdata, then validate.
- Error conditions:
  - funct3=7.
  - Store with funct3>3.
  - Misalignment: h needs addr[0]=0; w needs addr[1:0]=0; d needs addr[2:0]=0.
- On error: go to RESP with err=1 and no memory strobe.
- FSM states: IDLE, BEAT0, BEAT1, DRAIN, RESP.
  - BEAT0: mem_addr={addr[ADDR_W-1:2],2'b00}.
    - Load: mem_rd=1.
    - Store: mem_wr=1; mem_be = size mask (b 0001, h 0011, w/d 1111) << addr[1:0]; mem_wdata = wdata[31:0] << 8*addr[1:0].
    - Next state: d goes to BEAT1; other loads go to DRAIN; other stores go to RESP.
  - BEAT1: mem_addr = base+4. Store drives wdata[63:32] with be=1111. Load asserts mem_rd and captures the low word from mem_rdata. Next: load goes to DRAIN, store goes to RESP.
  - DRAIN: capture the last read word; go to RESP.
  - RESP: rsp_valid=1 for one cycle; return to IDLE. req_ready=0 here, so a request presented in RESP is taken the following cycle.
- Load extract: shift the word right by 8*addr[1:0], take 8/16/32 bits, then sign-extend (funct3 0,1,2) or zero-extend (4,5,6). d returns {hi,lo}.
- Latency from the accept cycle (cycle 0) to rsp_valid:
  - Error: cycle 1.
  - b/h/w store: cycle 2.
  - sd: cycle 3.
  - b/h/w load: cycle 3.
  - ld: cycle 4.
- Strobe rules:
  - mem_rd and mem_wr are never high together.
  - Strobes are decoded from the state register only.
  - No strobe is issued in IDLE, DRAIN or RESP.
- Reset mid-operation: the access is aborted, strobes drop asynchronously, and no response is issued. A half-written sd is not rolled back.
- req_addr bits [63:ADDR_W] are ignored unless the optional feature is enabled.

Optional Feature:
DMEM_BRIDGE_RANGE_CHK_EN.
- Defined: any nonzero bit in req_addr[63:ADDR_W] is an error. It responds at cycle 1 with err=1, the same as a misaligned access.
- Undefined: those upper bits are silently dropped.

Decomposition:
- Package dmem_bridge_pkg:
  - State enum.
  - F3_B/F3_H/F3_W/F3_D/F3_BU/F3_HU/F3_WU localparams.
  - Function size_of(funct3).
  - Function be_mask(size, off).
- One sub-module: dmem_load_align (combinational shift plus sign/zero extension, inputs word/off/funct3). It is reused for both the lo capture and the single-word capture.

Test Plan:
- sw addr 0x100, wdata 0xDEADBEEF → cycle1 mem_wr=1, addr 0x100, be 1111, wdata 0xDEADBEEF; cycle2 rsp_valid=1, err=0.
- With memory[0x100]=0xDEADBEEF: lb 0x103 → rsp_rdata 0xFFFFFFFFFFFFFFDE at cycle3; lbu 0x103 → 0xDE; lh 0x102 → 0xFFFFFFFFFFFFDEAD.
- sb 0x101, wdata 0xAA → be 0010, mem_wdata 0x0000AA00. A subsequent lw 0x100 returns 0xFFFFFFFFDEADAAEF.
- sd 0x108, wdata 0x1122334455667788 → beats (0x108, 0x55667788) then (0x10C, 0x11223344), rsp at cycle3. ld 0x108 → rsp_rdata 0x1122334455667788 at cycle4.
- Error cases, each with rsp at cycle1, err=1, rsp_rdata=ERR_RDATA and no mem_rd/mem_wr: sh 0x101; ld 0x104; load with funct3=7; store with funct3=5.
- rst low during BEAT1 of sd → mem_wr drops the same cycle and no rsp_valid; after release req_ready=1. DMEM_BRIDGE_RANGE_CHK_EN: lw 0x1_00000100 → err; without the macro the access goes to 0x100.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the dmem_bridge64 load/store bridge.
package dmem_bridge_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_DRAIN,
    ST_RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  // log2 of the access size in bytes
  function automatic logic [1:0] size_of(input logic [2:0] funct3);
    return funct3[1:0];
  endfunction

  function automatic logic [BE_W-1:0] be_mask(input logic [1:0] size, input logic [1:0] off);
    logic [BE_W-1:0] m;
    case (size)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Lane extraction plus sign/zero extension of one 32-bit memory word.
module dmem_load_align
  import dmem_bridge_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        funct3_i,
  output logic [XLEN-1:0]   data_o
);

  logic [WORD_W-1:0] sh;

  assign sh = word_i >> {off_i, 3'b000};

  // Doubleword halves pass through unshifted and zero-extended
  always_comb begin
    data_o = {32'd0, word_i};
    case (funct3_i)
      F3_B:    data_o = {{56{sh[7]}},  sh[7:0]};
      F3_H:    data_o = {{48{sh[15]}}, sh[15:0]};
      F3_W:    data_o = {{32{sh[31]}}, sh};
      F3_BU:   data_o = {56'd0, sh[7:0]};
      F3_HU:   data_o = {48'd0, sh[15:0]};
      F3_WU:   data_o = {32'd0, sh};
      default: data_o = {32'd0, word_i};
    endcase
  end

endmodule

// File: rtl/dmem_bridge64.sv
// 64-bit load/store bridge onto a 32-bit byte-enabled synchronous memory port.
// Optional upper-address range check: DMEM_BRIDGE_RANGE_CHK_EN.
module dmem_bridge64
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [63:0] ERR_RDATA = 64'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   align_data;
  logic [ADDR_W-1:0] base_addr;
  logic              range_err;
  logic              req_err_c;

`ifdef DMEM_BRIDGE_RANGE_CHK_EN
  assign range_err = (req_addr >> ADDR_W) != 64'd0;
`else
  logic unused_addr_hi;
  assign range_err      = 1'b0;
  assign unused_addr_hi = ^(req_addr >> ADDR_W);
`endif

  assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Request validation on the incoming (not yet latched) request
  always_comb begin
    req_err_c = range_err;
    if (req_funct3 == 3'd7)            req_err_c = 1'b1;
    if (req_write && req_funct3[2])    req_err_c = 1'b1;
    case (size_of(req_funct3))
      2'd1:    if (req_addr[0])              req_err_c = 1'b1;
      2'd2:    if (req_addr[1:0] != 2'd0)    req_err_c = 1'b1;
      2'd3:    if (req_addr[2:0] != 3'd0)    req_err_c = 1'b1;
      default: ;
    endcase
  end

  dmem_load_align u_align (
    .word_i   (mem_rdata),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (align_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:0];
          f3_d    = req_funct3;
          wr_d    = req_write;
          wdata_d = req_wdata;
          err_d   = req_err_c;
          data_d  = req_err_c ? ERR_RDATA : 64'd0;
          state_d = req_err_c ? ST_RESP : ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (f3_q == F3_D) state_d = ST_BEAT1;
        else if (wr_q)    state_d = ST_RESP;
        else              state_d = ST_DRAIN;
      end
      ST_BEAT1: begin
        if (wr_q) begin
          state_d = ST_RESP;
        end else begin
          data_d  = align_data;
          state_d = ST_DRAIN;
        end
      end
      // Read data for the last issued beat arrives here
      ST_DRAIN: begin
        data_d  = (f3_q == F3_D) ? {mem_rdata, data_q[31:0]} : align_data;
        state_d = ST_RESP;
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // Memory strobes decoded purely from registered state
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    case (state_q)
      ST_BEAT0: begin
        mem_addr = base_addr;
        mem_rd   = !wr_q;
        mem_wr   = wr_q;
        if (wr_q) begin
          mem_be    = be_mask(size_of(f3_q), addr_q[1:0]);
          mem_wdata = wdata_q[31:0] << {addr_q[1:0], 3'b000};
        end
      end
      ST_BEAT1: begin
        mem_addr = base_addr + ADDR_W'(4);
        mem_rd   = !wr_q;
        mem_wr   = wr_q;
        if (wr_q) begin
          mem_be    = 4'b1111;
          mem_wdata = wdata_q[63:32];
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = rsp_valid ? data_q : 64'd0;

endmodule

// File: tb/tb_dmem_bridge64.sv
// Directed self-checking bench for dmem_bridge64 with a behavioural 32-bit memory.
module tb_dmem_bridge64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_wr, mem_rd;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  int          rsp_cyc;
  logic [63:0] rsp_data;
  logic        rsp_e, rsp_rdy;
  int          strobe_cnt;
  logic        log_wr [8];
  logic        log_rd [8];
  logic [31:0] log_addr [8];
  logic [31:0] log_wdata [8];
  logic [3:0]  log_be [8];

  always #5 clk = ~clk;

  dmem_bridge64 #(.ADDR_W(32), .ERR_RDATA(64'h0)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_wr     (mem_wr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[9:2]];
    if (mem_wr)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_rd === 1'b1 && mem_wr === 1'b1) begin
      errors++;
      $display("FAIL strobe_exclusive: mem_rd and mem_wr both high at %0t", $time);
    end
  end

  // Issue one request and log the port activity of each following cycle until rsp_valid
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    rsp_cyc = -1; strobe_cnt = 0; rsp_data = 64'hx; rsp_e = 1'bx; rsp_rdy = 1'bx;
    for (int i = 0; i < 8; i++) begin
      log_wr[i] = 1'b0; log_rd[i] = 1'b0; log_addr[i] = 32'd0; log_wdata[i] = 32'd0; log_be[i] = 4'd0;
    end
    for (int c = 1; c < 8 && rsp_cyc < 0; c++) begin
      @(negedge clk);
      log_wr[c] = mem_wr; log_rd[c] = mem_rd; log_addr[c] = mem_addr;
      log_wdata[c] = mem_wdata; log_be[c] = mem_be;
      if (mem_wr || mem_rd) strobe_cnt++;
      if (rsp_valid) begin
        rsp_cyc = c; rsp_data = rsp_rdata; rsp_e = rsp_err; rsp_rdy = req_ready;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 64'd0; req_wdata = 64'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    checks++; if ({mem_wr, mem_rd} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_wr, mem_rd}); end
    checks++; if ({mem_addr, mem_wdata, mem_be} !== 68'd0) begin errors++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_addr, mem_wdata, mem_be}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_store_word();
    do_req(1'b1, 3'd2, 64'h100, 64'h0000_0000_DEAD_BEEF);
    checks++; if (log_wr[1] !== 1'b1) begin errors++; $display("FAIL sw_wr: got %b expected 1", log_wr[1]); end
    checks++; if (log_addr[1] !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h expected 100", log_addr[1]); end
    checks++; if (log_be[1] !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", log_be[1]); end
    checks++; if (log_wdata[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", log_wdata[1]); end
    checks++; if (rsp_cyc !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", rsp_cyc); end
    checks++; if (rsp_e !== 1'b0 || rsp_data !== 64'd0) begin errors++; $display("FAIL sw_rsp: got err %b data %h expected 0/0", rsp_e, rsp_data); end
    checks++; if (rsp_rdy !== 1'b0) begin errors++; $display("FAIL sw_ready_in_resp: got %b expected 0", rsp_rdy); end
  endtask

  task automatic test_sub_loads();
    do_req(1'b0, 3'd0, 64'h103, 64'd0);
    checks++; if (log_rd[1] !== 1'b1 || log_addr[1] !== 32'h100) begin errors++; $display("FAIL lb_beat: got rd %b addr %h expected 1/100", log_rd[1], log_addr[1]); end
    checks++; if (rsp_cyc !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", rsp_cyc); end
    checks++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_FFDE) begin errors++; $display("FAIL lb_data: got %h expected ffffffffffffffde", rsp_data); end
    do_req(1'b0, 3'd4, 64'h103, 64'd0);
    checks++; if (rsp_data !== 64'h0000_0000_0000_00DE) begin errors++; $display("FAIL lbu_data: got %h expected de", rsp_data); end
    do_req(1'b0, 3'd1, 64'h102, 64'd0);
    checks++; if (rsp_data !== 64'hFFFF_FFFF_FFFF_DEAD) begin errors++; $display("FAIL lh_data: got %h expected ffffffffffffdead", rsp_data); end
    checks++; if (rsp_cyc !== 3 || rsp_e !== 1'b0) begin errors++; $display("FAIL lh_rsp: got cyc %0d err %b expected 3/0", rsp_cyc, rsp_e); end
  endtask

  task automatic test_store_byte();
    do_req(1'b1, 3'd0, 64'h101, 64'h0000_0000_0000_00AA);
    checks++; if (log_be[1] !== 4'b0010) begin errors++; $display("FAIL sb_be: got %b expected 0010", log_be[1]); end
    checks++; if (log_wdata[1] !== 32'h0000AA00) begin errors++; $display("FAIL sb_wdata: got %h expected 0000aa00", log_wdata[1]); end
    checks++; if (rsp_cyc !== 2) begin errors++; $display("FAIL sb_latency: got %0d expected 2", rsp_cyc); end
    do_req(1'b0, 3'd2, 64'h100, 64'd0);
    checks++; if (rsp_data !== 64'hFFFF_FFFF_DEAD_AAEF) begin errors++; $display("FAIL lw_after_sb: got %h expected ffffffffdeadaaef", rsp_data); end
    do_req(1'b0, 3'd5, 64'h100, 64'd0);
    checks++; if (rsp_data !== 64'h0000_0000_0000_AAEF) begin errors++; $display("FAIL lhu_data: got %h expected aaef", rsp_data); end
    do_req(1'b0, 3'd6, 64'h100, 64'd0);
    checks++; if (rsp_data !== 64'h0000_0000_DEAD_AAEF) begin errors++; $display("FAIL lwu_data: got %h expected deadaaef", rsp_data); end
  endtask

  task automatic test_doubleword();
    do_req(1'b1, 3'd3, 64'h108, 64'h1122_3344_5566_7788);
    checks++; if (log_wr[1] !== 1'b1 || log_addr[1] !== 32'h108 || log_wdata[1] !== 32'h55667788 || log_be[1] !== 4'hF)
      begin errors++; $display("FAIL sd_beat0: got wr %b addr %h data %h be %b expected 1/108/55667788/1111", log_wr[1], log_addr[1], log_wdata[1], log_be[1]); end
    checks++; if (log_wr[2] !== 1'b1 || log_addr[2] !== 32'h10C || log_wdata[2] !== 32'h11223344 || log_be[2] !== 4'hF)
      begin errors++; $display("FAIL sd_beat1: got wr %b addr %h data %h be %b expected 1/10c/11223344/1111", log_wr[2], log_addr[2], log_wdata[2], log_be[2]); end
    checks++; if (rsp_cyc !== 3) begin errors++; $display("FAIL sd_latency: got %0d expected 3", rsp_cyc); end
    do_req(1'b0, 3'd3, 64'h108, 64'd0);
    checks++; if (log_rd[1] !== 1'b1 || log_rd[2] !== 1'b1 || log_addr[2] !== 32'h10C)
      begin errors++; $display("FAIL ld_beats: got rd %b%b addr1 %h expected 11/10c", log_rd[1], log_rd[2], log_addr[2]); end
    checks++; if (rsp_cyc !== 4) begin errors++; $display("FAIL ld_latency: got %0d expected 4", rsp_cyc); end
    checks++; if (rsp_data !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL ld_data: got %h expected 1122334455667788", rsp_data); end
    checks++; if (strobe_cnt !== 2) begin errors++; $display("FAIL ld_strobe_count: got %0d expected 2", strobe_cnt); end
  endtask

  task automatic test_errors();
    logic        ew [4];
    logic [2:0]  ef [4];
    logic [63:0] ea [4];
    ew[0] = 1'b1; ef[0] = 3'd1; ea[0] = 64'h101;
    ew[1] = 1'b0; ef[1] = 3'd3; ea[1] = 64'h104;
    ew[2] = 1'b0; ef[2] = 3'd7; ea[2] = 64'h100;
    ew[3] = 1'b1; ef[3] = 3'd5; ea[3] = 64'h100;
    for (int k = 0; k < 4; k++) begin
      do_req(ew[k], ef[k], ea[k], 64'hFFFF_FFFF_FFFF_FFFF);
      checks++; if (rsp_cyc !== 1) begin errors++; $display("FAIL err%0d_latency: got %0d expected 1", k, rsp_cyc); end
      checks++; if (rsp_e !== 1'b1) begin errors++; $display("FAIL err%0d_flag: got %b expected 1", k, rsp_e); end
      checks++; if (rsp_data !== 64'h0) begin errors++; $display("FAIL err%0d_rdata: got %h expected 0", k, rsp_data); end
      checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL err%0d_strobes: got %0d expected 0", k, strobe_cnt); end
    end
  endtask

  task automatic test_reset_mid_op();
    logic seen_rsp;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd3;
    req_addr = 64'h110; req_wdata = 64'hCAFE_F00D_1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_wr !== 1'b1 || mem_addr !== 32'h114) begin errors++; $display("FAIL mid_beat1: got wr %b addr %h expected 1/114", mem_wr, mem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL mid_strobe_drop: got wr %b rd %b expected 0/0", mem_wr, mem_rd); end
    seen_rsp = 1'b0;
    repeat (2) begin @(negedge clk); if (rsp_valid) seen_rsp = 1'b1; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen_rsp = 1'b1; end
    checks++; if (seen_rsp !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got %b expected 0", seen_rsp); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", req_ready); end
    checks++; if (mem[8'h44] !== 32'h12345678 || mem[8'h45] !== 32'h0)
      begin errors++; $display("FAIL mid_partial_write: got %h %h expected 12345678 00000000", mem[8'h44], mem[8'h45]); end
  endtask

  task automatic test_range();
    do_req(1'b0, 3'd2, 64'h1_0000_0100, 64'd0);
`ifdef DMEM_BRIDGE_RANGE_CHK_EN
    checks++; if (rsp_cyc !== 1 || rsp_e !== 1'b1) begin errors++; $display("FAIL range_err: got cyc %0d err %b expected 1/1", rsp_cyc, rsp_e); end
    checks++; if (strobe_cnt !== 0) begin errors++; $display("FAIL range_strobes: got %0d expected 0", strobe_cnt); end
`else
    checks++; if (log_rd[1] !== 1'b1 || log_addr[1] !== 32'h100) begin errors++; $display("FAIL range_drop_addr: got rd %b addr %h expected 1/100", log_rd[1], log_addr[1]); end
    checks++; if (rsp_cyc !== 3 || rsp_e !== 1'b0 || rsp_data !== 64'hFFFF_FFFF_DEAD_AAEF)
      begin errors++; $display("FAIL range_drop_rsp: got cyc %0d err %b data %h expected 3/0/ffffffffdeadaaef", rsp_cyc, rsp_e, rsp_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_sub_loads();
    test_store_byte();
    test_doubleword();
    test_errors();
    test_reset_mid_op();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
